// File: rtl/hazard_pkg.sv
// Shared types and defaults for the D-stage hazard scoreboard.
package hazard_pkg;

    localparam int AW_DEF       = 5;
    localparam int TW_DEF       = 2;
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    // All-ones Tuse marks an operand the instruction does not read.
    localparam logic [TW_DEF-1:0] TUSE_NONE = {TW_DEF{1'b1}};

    typedef struct packed {
        logic [AW_DEF-1:0] a3;
        logic [TW_DEF-1:0] tnew;
    } entry_t;

    // Wide enough for any supported depth (NSTAGE up to 7).
    typedef logic [2:0] stage_idx_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_md_ctr.sv
// Mult/div busy timer: loads the unit latency on a start, then counts down to 0.
module hazard_md_ctr
    import hazard_pkg::*;
#(
    parameter  int MULT_CYC = MULT_CYC_DEF,
    parameter  int DIV_CYC  = DIV_CYC_DEF,
    localparam int CW       = $clog2(max_int(MULT_CYC, DIV_CYC) + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic div,
    output logic md_busy
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= div ? CW'(DIV_CYC) : CW'(MULT_CYC);
        else if (cnt != '0)
            cnt <= cnt - CW'(1);
    end

    assign md_busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage stall / forwarding unit tracking in-flight writers over NSTAGE stages.
// Define HAZARD_MD_EN to add the mult/div busy timer and its stall term.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int NSTAGE   = 3,
    parameter  int AW       = AW_DEF,
    parameter  int TW       = TW_DEF,
    parameter  int MULT_CYC = MULT_CYC_DEF,
    parameter  int DIV_CYC  = DIV_CYC_DEF,
    localparam int SW       = $clog2(NSTAGE + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          d_valid,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic [AW-1:0] d_a3,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_is_md,
    input  logic          d_md_start,
    input  logic          d_md_div,
    input  logic          flush,
    output logic          stall,
    output logic [SW-1:0] fwd_rs_sel,
    output logic [SW-1:0] fwd_rt_sel,
    output logic          md_busy
);

    localparam logic [TW-1:0] NONE = {TW{1'b1}};

    typedef struct packed {
        logic [AW-1:0] a3;
        logic [TW-1:0] tnew;
    } ent_t;

    ent_t e [1:NSTAGE];
    logic hz_rs, hz_rt, md_hz, issue;

    // Walk oldest to youngest so the lowest-k match is the one that sticks.
    always_comb begin
        hz_rs      = 1'b0;
        hz_rt      = 1'b0;
        fwd_rs_sel = '0;
        fwd_rt_sel = '0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (d_rs != '0 && d_tuse_rs != NONE && e[k].a3 == d_rs) begin
                hz_rs      = (e[k].tnew > d_tuse_rs);
                fwd_rs_sel = (e[k].tnew == '0) ? SW'(k) : '0;
            end
            if (d_rt != '0 && d_tuse_rt != NONE && e[k].a3 == d_rt) begin
                hz_rt      = (e[k].tnew > d_tuse_rt);
                fwd_rt_sel = (e[k].tnew == '0) ? SW'(k) : '0;
            end
        end
    end

    assign stall = d_valid && (hz_rs || hz_rt || md_hz);
    assign issue = d_valid && !stall && !flush;

`ifdef HAZARD_MD_EN
    hazard_md_ctr #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (issue && d_md_start),
        .div     (d_md_div),
        .md_busy (md_busy)
    );
    assign md_hz = d_is_md && md_busy;
`else
    logic unused_md;
    assign unused_md = &{1'b0, d_is_md, d_md_start, d_md_div};
    assign md_busy   = 1'b0;
    assign md_hz     = 1'b0;
`endif

    // Entries age one stage per cycle; tnew counts down and holds at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= NSTAGE; k++) e[k] <= '0;
        end else begin
            e[1] <= issue ? ent_t'{a3: d_a3, tnew: d_tnew} : '0;
            for (int k = 2; k <= NSTAGE; k++) begin
                if (flush)
                    e[k] <= '0;
                else
                    e[k] <= ent_t'{a3:   e[k-1].a3,
                                   tnew: (e[k-1].tnew == '0) ? '0 : e[k-1].tnew - TW'(1)};
            end
        end
    end

endmodule
